// File: rtl/fp_normalize_pipe.sv
// Normalization-shift stage: per-lane leading-zero count (or FTOI shift) registered
// alongside the add operands, with an optional two-cycle half-split LZC and a global stall.

module fp_norm_lane #(
   parameter int SIG_WIDTH   = 32,
   parameter int SHIFT_WIDTH = $clog2(SIG_WIDTH) + 1,
   parameter int LATENCY     = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   is_ftoi,
   input  logic [SHIFT_WIDTH-1:0] ftoi_lshift,
   input  logic [SIG_WIDTH-1:0]   significand,
   output logic [SHIFT_WIDTH-1:0] norm_shift,
   output logic                   is_zero
);
   localparam int HALF  = SIG_WIDTH / 2;
   localparam int HLZ_W = $clog2(HALF) + 1;

   function automatic logic [HLZ_W-1:0] lzc_half(input logic [HALF-1:0] v);
      logic [HLZ_W-1:0] n;
      logic             seen;
      n    = '0;
      seen = 1'b0;
      for (int i = HALF - 1; i >= 0; i--) begin
         seen = seen | v[i];
         if (!seen) n = n + HLZ_W'(1);
      end
      return n;
   endfunction

   logic [HLZ_W-1:0] hi_lz, lo_lz;
   logic             hi_zero, lo_zero;

   always_comb begin
      hi_lz   = lzc_half(significand[SIG_WIDTH-1:HALF]);
      lo_lz   = lzc_half(significand[HALF-1:0]);
      hi_zero = ~|significand[SIG_WIDTH-1:HALF];
      lo_zero = ~|significand[HALF-1:0];
   end

   // Inputs to the final combine: straight from the halves, or from stage A flops.
   logic [HLZ_W-1:0]       b_hi_lz, b_lo_lz;
   logic                   b_hi_zero, b_lo_zero, b_is_ftoi;
   logic [SHIFT_WIDTH-1:0] b_ftoi_lshift;

   generate
      if (LATENCY == 2) begin : g_split
         logic [HLZ_W-1:0]       hi_lz_q, hi_lz_d, lo_lz_q, lo_lz_d;
         logic                   hi_zero_q, hi_zero_d, lo_zero_q, lo_zero_d;
         logic                   is_ftoi_q, is_ftoi_d;
         logic [SHIFT_WIDTH-1:0] ftoi_lshift_q, ftoi_lshift_d;

         always_comb begin
            hi_lz_d       = hi_lz_q;
            lo_lz_d       = lo_lz_q;
            hi_zero_d     = hi_zero_q;
            lo_zero_d     = lo_zero_q;
            is_ftoi_d     = is_ftoi_q;
            ftoi_lshift_d = ftoi_lshift_q;
            if (!stall) begin
               hi_lz_d       = hi_lz;
               lo_lz_d       = lo_lz;
               hi_zero_d     = hi_zero;
               lo_zero_d     = lo_zero;
               is_ftoi_d     = is_ftoi;
               ftoi_lshift_d = ftoi_lshift;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               hi_lz_q       <= '0;
               lo_lz_q       <= '0;
               hi_zero_q     <= 1'b0;
               lo_zero_q     <= 1'b0;
               is_ftoi_q     <= 1'b0;
               ftoi_lshift_q <= '0;
            end else begin
               hi_lz_q       <= hi_lz_d;
               lo_lz_q       <= lo_lz_d;
               hi_zero_q     <= hi_zero_d;
               lo_zero_q     <= lo_zero_d;
               is_ftoi_q     <= is_ftoi_d;
               ftoi_lshift_q <= ftoi_lshift_d;
            end
         end

         assign b_hi_lz       = hi_lz_q;
         assign b_lo_lz       = lo_lz_q;
         assign b_hi_zero     = hi_zero_q;
         assign b_lo_zero     = lo_zero_q;
         assign b_is_ftoi     = is_ftoi_q;
         assign b_ftoi_lshift = ftoi_lshift_q;
      end else begin : g_flat
         assign b_hi_lz       = hi_lz;
         assign b_lo_lz       = lo_lz;
         assign b_hi_zero     = hi_zero;
         assign b_lo_zero     = lo_zero;
         assign b_is_ftoi     = is_ftoi;
         assign b_ftoi_lshift = ftoi_lshift;
      end
   endgenerate

   logic [SHIFT_WIDTH-1:0] norm_shift_q, norm_shift_d;
   logic                   is_zero_q, is_zero_d;

   always_comb begin
      norm_shift_d = norm_shift_q;
      is_zero_d    = is_zero_q;
      if (!stall) begin
         if (b_is_ftoi)
            norm_shift_d = b_ftoi_lshift;
         else if (b_hi_zero)
            norm_shift_d = SHIFT_WIDTH'(HALF) + SHIFT_WIDTH'(b_lo_lz);
         else
            norm_shift_d = SHIFT_WIDTH'(b_hi_lz);
         is_zero_d = !b_is_ftoi && b_hi_zero && b_lo_zero;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         norm_shift_q <= '0;
         is_zero_q    <= 1'b0;
      end else begin
         norm_shift_q <= norm_shift_d;
         is_zero_q    <= is_zero_d;
      end
   end

   assign norm_shift = norm_shift_q;
   assign is_zero    = is_zero_q;
endmodule

module fp_normalize_pipe #(
   parameter int NUM_LANES   = 16,
   parameter int SIG_WIDTH   = 32,
   parameter int LATENCY     = 1,
   parameter int SHIFT_WIDTH = $clog2(SIG_WIDTH) + 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             stall,
   input  logic                             in_valid,
   input  logic [NUM_LANES-1:0]             in_mask,
   input  logic [1:0]                       in_thread_idx,
   input  logic [3:0]                       in_subcycle,
   input  logic                             in_is_ftoi,
   input  logic [NUM_LANES*SHIFT_WIDTH-1:0] in_ftoi_lshift,
   input  logic [NUM_LANES*SIG_WIDTH-1:0]   in_significand,
   input  logic [NUM_LANES*8-1:0]           in_exponent,
   input  logic [NUM_LANES-1:0]             in_sign,
   input  logic [NUM_LANES-1:0]             in_logical_subtract,
   output logic                             out_valid,
   output logic [NUM_LANES-1:0]             out_mask,
   output logic [1:0]                       out_thread_idx,
   output logic [3:0]                       out_subcycle,
   output logic [NUM_LANES*SIG_WIDTH-1:0]   out_significand,
   output logic [NUM_LANES*8-1:0]           out_exponent,
   output logic [NUM_LANES-1:0]             out_sign,
   output logic [NUM_LANES-1:0]             out_logical_subtract,
   output logic [NUM_LANES*SHIFT_WIDTH-1:0] out_norm_shift,
   output logic [NUM_LANES-1:0]             out_is_zero
);
   generate
      if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
         $error("fp_normalize_pipe: LATENCY must be 1 or 2");
      end
      if ((SIG_WIDTH % 2) != 0 || SIG_WIDTH < 8 || SIG_WIDTH > 64) begin : g_bad_width
         $error("fp_normalize_pipe: SIG_WIDTH must be even and within 8..64");
      end
   endgenerate

   localparam int DW = 3 * NUM_LANES + 6 + NUM_LANES * (SIG_WIDTH + 8);

   logic [DW-1:0]             data_in;
   logic [LATENCY:1][DW-1:0]  data_pipe_q, data_pipe_d;
   logic [LATENCY:1]          vld_pipe_q, vld_pipe_d;

   assign data_in = {in_mask, in_thread_idx, in_subcycle, in_significand,
                     in_exponent, in_sign, in_logical_subtract};

   // Operands and valid ride a plain delay line matching the lane latency.
   always_comb begin
      vld_pipe_d  = vld_pipe_q;
      data_pipe_d = data_pipe_q;
      if (!stall) begin
         vld_pipe_d[1]  = in_valid;
         data_pipe_d[1] = data_in;
         for (int i = 2; i <= LATENCY; i++) begin
            vld_pipe_d[i]  = vld_pipe_q[i-1];
            data_pipe_d[i] = data_pipe_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_pipe_q  <= '0;
         data_pipe_q <= '0;
      end else begin
         vld_pipe_q  <= vld_pipe_d;
         data_pipe_q <= data_pipe_d;
      end
   end

   assign out_valid = vld_pipe_q[LATENCY];
   assign {out_mask, out_thread_idx, out_subcycle, out_significand,
           out_exponent, out_sign, out_logical_subtract} = data_pipe_q[LATENCY];

   fp_norm_lane #(
      .SIG_WIDTH  (SIG_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH),
      .LATENCY    (LATENCY)
   ) u_lane [NUM_LANES-1:0] (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .is_ftoi    (in_is_ftoi),
      .ftoi_lshift(in_ftoi_lshift),
      .significand(in_significand),
      .norm_shift (out_norm_shift),
      .is_zero    (out_is_zero)
   );
endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Bench for fp_normalize_pipe: 16x32 at latency 1 and 2 share stimulus; a 4x24 latency-2
// variant runs its own random stream. Scoreboards use a log2-based LZC reference.

module tb_fp_normalize_pipe;
   localparam int NL = 16, SW = 32, SH = 6;
   localparam int VNL = 4, VSW = 24, VSH = 6;

   typedef struct packed {
      logic [NL-1:0]         mask;
      logic [1:0]            tid;
      logic [3:0]            sub;
      logic [NL-1:0][SW-1:0] sig;
      logic [NL-1:0][7:0]    expo;
      logic [NL-1:0]         sign;
      logic [NL-1:0]         lsub;
      logic [NL-1:0][SH-1:0] shift;
      logic [NL-1:0]         zero;
   } rec_t;

   typedef struct packed {
      logic [49:0]             side;
      logic [VNL-1:0][VSW-1:0] sig;
      logic [VNL-1:0][VSH-1:0] shift;
      logic [VNL-1:0]          zero;
   } vrec_t;

   typedef struct {
      logic [SW-1:0] sig;
      logic          ftoi;
      logic [SH-1:0] lsh;
      logic [SH-1:0] exp_shift;
      logic          exp_zero;
   } vec_t;

   logic clk = 1'b0, reset, stall, in_valid, in_is_ftoi;
   logic [NL-1:0] in_mask, in_sign, in_lsub;
   logic [1:0] in_tid;
   logic [3:0] in_sub;
   logic [NL-1:0][SH-1:0] in_ftoi;
   logic [NL-1:0][SW-1:0] in_sig;
   logic [NL-1:0][7:0] in_exp;

   logic o1_valid, o2_valid;
   logic [NL-1:0] o1_mask, o2_mask, o1_sign, o2_sign, o1_lsub, o2_lsub, o1_zero, o2_zero;
   logic [1:0] o1_tid, o2_tid;
   logic [3:0] o1_sub, o2_sub;
   logic [NL-1:0][SW-1:0] o1_sig, o2_sig;
   logic [NL-1:0][7:0] o1_exp, o2_exp;
   logic [NL-1:0][SH-1:0] o1_shift, o2_shift;

   logic v_in_valid, v_is_ftoi, vo_valid;
   logic [VNL-1:0] v_mask, v_sign, v_lsub, vo_mask, vo_sign, vo_lsub, vo_zero;
   logic [1:0] v_tid, vo_tid;
   logic [3:0] v_sub, vo_sub;
   logic [VNL-1:0][VSH-1:0] v_ftoi, vo_shift;
   logic [VNL-1:0][VSW-1:0] v_sig, vo_sig;
   logic [VNL-1:0][7:0] v_exp, vo_exp;

   always #5 clk = ~clk;

   fp_normalize_pipe #(.NUM_LANES(NL), .SIG_WIDTH(SW), .LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_mask(in_mask),
      .in_thread_idx(in_tid), .in_subcycle(in_sub), .in_is_ftoi(in_is_ftoi),
      .in_ftoi_lshift(in_ftoi), .in_significand(in_sig), .in_exponent(in_exp),
      .in_sign(in_sign), .in_logical_subtract(in_lsub), .out_valid(o1_valid),
      .out_mask(o1_mask), .out_thread_idx(o1_tid), .out_subcycle(o1_sub),
      .out_significand(o1_sig), .out_exponent(o1_exp), .out_sign(o1_sign),
      .out_logical_subtract(o1_lsub), .out_norm_shift(o1_shift), .out_is_zero(o1_zero));

   fp_normalize_pipe #(.NUM_LANES(NL), .SIG_WIDTH(SW), .LATENCY(2)) u_l2 (
      .clk(clk), .reset(reset), .stall(stall), .in_valid(in_valid), .in_mask(in_mask),
      .in_thread_idx(in_tid), .in_subcycle(in_sub), .in_is_ftoi(in_is_ftoi),
      .in_ftoi_lshift(in_ftoi), .in_significand(in_sig), .in_exponent(in_exp),
      .in_sign(in_sign), .in_logical_subtract(in_lsub), .out_valid(o2_valid),
      .out_mask(o2_mask), .out_thread_idx(o2_tid), .out_subcycle(o2_sub),
      .out_significand(o2_sig), .out_exponent(o2_exp), .out_sign(o2_sign),
      .out_logical_subtract(o2_lsub), .out_norm_shift(o2_shift), .out_is_zero(o2_zero));

   fp_normalize_pipe #(.NUM_LANES(VNL), .SIG_WIDTH(VSW), .LATENCY(2)) u_var (
      .clk(clk), .reset(reset), .stall(stall), .in_valid(v_in_valid), .in_mask(v_mask),
      .in_thread_idx(v_tid), .in_subcycle(v_sub), .in_is_ftoi(v_is_ftoi),
      .in_ftoi_lshift(v_ftoi), .in_significand(v_sig), .in_exponent(v_exp),
      .in_sign(v_sign), .in_logical_subtract(v_lsub), .out_valid(vo_valid),
      .out_mask(vo_mask), .out_thread_idx(vo_tid), .out_subcycle(vo_sub),
      .out_significand(vo_sig), .out_exponent(vo_exp), .out_sign(vo_sign),
      .out_logical_subtract(vo_lsub), .out_norm_shift(vo_shift), .out_is_zero(vo_zero));

   rec_t  r1, r2;
   vrec_t rv;
   assign r1 = {o1_mask, o1_tid, o1_sub, o1_sig, o1_exp, o1_sign, o1_lsub, o1_shift, o1_zero};
   assign r2 = {o2_mask, o2_tid, o2_sub, o2_sig, o2_exp, o2_sign, o2_lsub, o2_shift, o2_zero};
   assign rv = {{vo_mask, vo_tid, vo_sub, vo_exp, vo_sign, vo_lsub}, vo_sig, vo_shift, vo_zero};

   int total = 0, bad = 0, tick = 0, cyc = 0;
   bit adv = 0;
   rec_t q1[$], q2[$];
   vrec_t qv[$];
   int t1[$], t2[$], tv_q[$], log_id[$], log_cy[$];

   task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   // Reference LZC: width minus the bit length of the value.
   function automatic int lzc_ref(input longint unsigned v, input int w);
      return w - $clog2(v + 1);
   endfunction

   function automatic rec_t model_main();
      rec_t m;
      m = {in_mask, in_tid, in_sub, in_sig, in_exp, in_sign, in_lsub, {NL*SH{1'b0}}, {NL{1'b0}}};
      for (int l = 0; l < NL; l++) begin
         m.shift[l] = in_is_ftoi ? in_ftoi[l] : SH'(lzc_ref(longint'(in_sig[l]), SW));
         m.zero[l]  = !in_is_ftoi && (in_sig[l] == 0);
      end
      return m;
   endfunction

   function automatic vrec_t model_var();
      vrec_t m;
      m.side = {v_mask, v_tid, v_sub, v_exp, v_sign, v_lsub};
      m.sig  = v_sig;
      for (int l = 0; l < VNL; l++) begin
         m.shift[l] = v_is_ftoi ? v_ftoi[l] : VSH'(lzc_ref(longint'(v_sig[l]), VSW));
         m.zero[l]  = !v_is_ftoi && (v_sig[l] == 0);
      end
      return m;
   endfunction

   always @(posedge clk) begin
      cyc++;
      adv = 1'b0;
      if (!reset && !stall) begin
         adv = 1'b1;
         tick++;
         if (in_valid) begin
            q1.push_back(model_main()); t1.push_back(tick);
            q2.push_back(model_main()); t2.push_back(tick);
         end
         if (v_in_valid) begin
            qv.push_back(model_var()); tv_q.push_back(tick);
         end
      end
   end

   task automatic sb(input int which, input logic ov, input rec_t got);
      rec_t e;
      int   t;
      if (!ov) return;
      if ((which == 1 && q1.size() == 0) || (which == 2 && q2.size() == 0)) begin
         total++; bad++;
         $display("FAIL L%0d unexpected out_valid: got 1 want 0", which);
         return;
      end
      if (which == 1) begin e = q1.pop_front(); t = t1.pop_front(); end
      else begin e = q2.pop_front(); t = t2.pop_front(); log_id.push_back(int'(got.sub)); log_cy.push_back(cyc); end
      chk($sformatf("L%0d shift", which), 512'(got.shift), 512'(e.shift));
      chk($sformatf("L%0d zero", which), 512'(got.zero), 512'(e.zero));
      chk($sformatf("L%0d sig", which), 512'(got.sig), 512'(e.sig));
      chk($sformatf("L%0d side", which), 512'({got.mask, got.tid, got.sub, got.expo, got.sign, got.lsub}),
          512'({e.mask, e.tid, e.sub, e.expo, e.sign, e.lsub}));
      chk($sformatf("L%0d latency", which), 512'(tick - t), 512'(which - 1));
   endtask

   always @(negedge clk) begin
      if (!reset && adv) begin
         sb(1, o1_valid, r1);
         sb(2, o2_valid, r2);
         if (vo_valid) begin
            if (qv.size() == 0) begin
               total++; bad++;
               $display("FAIL var unexpected out_valid: got 1 want 0");
            end else begin
               vrec_t e;
               int    t;
               e = qv.pop_front(); t = tv_q.pop_front();
               chk("var shift", 512'(rv.shift), 512'(e.shift));
               chk("var zero", 512'(rv.zero), 512'(e.zero));
               chk("var data", 512'({rv.side, rv.sig}), 512'({e.side, e.sig}));
               chk("var latency", 512'(tick - t), 512'(1));
            end
         end
      end
   end

   function automatic longint unsigned rsig(input int w);
      longint unsigned m;
      m = (64'd1 << w) - 1;
      case ($urandom_range(4, 0))
         0: return 0;
         1: return m;
         2: return 1;
         3: return ({$urandom, $urandom} & m) >> $urandom_range(w - 1, 0);
         default: return 64'd1 << $urandom_range(w - 1, 0);
      endcase
   endfunction

   task automatic rand_main();
      in_valid   = ($urandom_range(3, 0) != 0);
      in_is_ftoi = ($urandom_range(3, 0) == 0);
      in_mask    = NL'($urandom);
      in_tid     = 2'($urandom);
      in_sub     = 4'($urandom);
      in_sign    = NL'($urandom);
      in_lsub    = NL'($urandom);
      for (int l = 0; l < NL; l++) begin
         in_sig[l]  = SW'(rsig(SW));
         in_ftoi[l] = SH'($urandom_range(SW, 0));
         in_exp[l]  = 8'($urandom);
      end
   endtask

   task automatic rand_var();
      v_in_valid = ($urandom_range(3, 0) != 0);
      v_is_ftoi  = ($urandom_range(4, 0) == 0);
      v_mask     = VNL'($urandom);
      v_tid      = 2'($urandom);
      v_sub      = 4'($urandom);
      v_sign     = VNL'($urandom);
      v_lsub     = VNL'($urandom);
      for (int l = 0; l < VNL; l++) begin
         v_sig[l]  = VSW'(rsig(VSW));
         v_ftoi[l] = VSH'($urandom_range(VSW, 0));
         v_exp[l]  = 8'($urandom);
      end
   endtask

   initial begin
      vec_t tv[$];
      logic [NL-1:0][SH-1:0] es;
      reset = 1'b1; stall = 1'b0;
      in_valid = 0; in_is_ftoi = 0; in_mask = '0; in_tid = '0; in_sub = '0;
      in_sig = '0; in_ftoi = '0; in_exp = '0; in_sign = '0; in_lsub = '0;
      v_in_valid = 0; v_is_ftoi = 0; v_mask = '0; v_tid = '0; v_sub = '0;
      v_sig = '0; v_ftoi = '0; v_exp = '0; v_sign = '0; v_lsub = '0;

      for (int k = SW - 1; k >= 0; k--)
         tv.push_back('{sig: SW'(1) << k, ftoi: 1'b0, lsh: '0, exp_shift: SH'(SW - 1 - k), exp_zero: 1'b0});
      tv.push_back('{sig: '0, ftoi: 1'b0, lsh: '0, exp_shift: SH'(SW), exp_zero: 1'b1});
      tv.push_back('{sig: '0, ftoi: 1'b1, lsh: SH'(17), exp_shift: SH'(17), exp_zero: 1'b0});
      tv.push_back('{sig: 32'h0000_8000, ftoi: 1'b0, lsh: '0, exp_shift: SH'(16), exp_zero: 1'b0});
      tv.push_back('{sig: 32'h0001_0000, ftoi: 1'b0, lsh: '0, exp_shift: SH'(15), exp_zero: 1'b0});
      tv.push_back('{sig: 32'h0000_0001, ftoi: 1'b0, lsh: '0, exp_shift: SH'(31), exp_zero: 1'b0});
      tv.push_back('{sig: 32'hFFFF_FFFF, ftoi: 1'b0, lsh: '0, exp_shift: SH'(0), exp_zero: 1'b0});

      repeat (2) @(negedge clk);
      chk("reset valid", 512'({o1_valid, o2_valid, vo_valid}), 512'(0));
      chk("reset l1 data", 512'(r1.sig) | 512'({r1.shift, r1.zero, r1.mask}), 512'(0));
      chk("reset l2 data", 512'(r2.sig) | 512'({r2.shift, r2.zero, r2.mask}), 512'(0));
      chk("reset var data", 512'(rv), 512'(0));
      reset = 1'b0;
      @(negedge clk);

      foreach (tv[i]) begin
         for (int l = 0; l < NL; l++) begin
            in_sig[l] = tv[i].sig; in_ftoi[l] = tv[i].lsh; es[l] = tv[i].exp_shift;
         end
         in_is_ftoi = tv[i].ftoi; in_valid = 1'b1;
         @(negedge clk);
         in_valid = 1'b0;
         chk($sformatf("tbl%0d l1 valid", i), 512'(o1_valid), 512'(1));
         chk($sformatf("tbl%0d l1 shift", i), 512'(o1_shift), 512'(es));
         chk($sformatf("tbl%0d l1 zero", i), 512'(o1_zero), 512'({NL{tv[i].exp_zero}}));
         @(negedge clk);
         chk($sformatf("tbl%0d l2 valid", i), 512'(o2_valid), 512'(1));
         chk($sformatf("tbl%0d l2 shift", i), 512'(o2_shift), 512'(es));
         chk($sformatf("tbl%0d l2 zero", i), 512'(o2_zero), 512'({NL{tv[i].exp_zero}}));
      end
      in_is_ftoi = 1'b0;

      // Random stream with random stalls; inputs only change after an unstalled edge.
      for (int c = 0; c < 200; c++) begin
         if (!stall) rand_main();
         stall = ($urandom_range(7, 0) == 0);
         @(negedge clk);
      end
      stall = 1'b0; in_valid = 1'b0;
      repeat (3) @(negedge clk);

      // IDs 1..6 back-to-back, 3-cycle stall once ID 3 has entered.
      log_id.delete(); log_cy.delete();
      for (int id = 1; id <= 6; id++) begin
         rand_main();
         in_valid = 1'b1; in_sub = 4'(id);
         if (id == 4) begin
            stall = 1'b1;
            repeat (3) @(negedge clk);
            stall = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("stall count", 512'(log_id.size()), 512'(6));
      for (int k = 0; k < log_id.size() && k < 6; k++) begin
         chk($sformatf("stall id%0d", k), 512'(log_id[k]), 512'(k + 1));
         chk($sformatf("stall cyc%0d", k), 512'(log_cy[k] - log_cy[0]), 512'(k + ((k >= 2) ? 3 : 0)));
      end

      // Reset between edges with two instructions inside the latency-2 pipe.
      rand_main(); in_valid = 1'b1;
      @(negedge clk);
      rand_main(); in_valid = 1'b1;
      @(posedge clk);
      #2 reset = 1'b1;
      q1.delete(); q2.delete(); qv.delete(); t1.delete(); t2.delete(); tv_q.delete();
      #1;
      chk("midreset valid", 512'({o1_valid, o2_valid}), 512'(0));
      chk("midreset l2 shift", 512'(o2_shift), 512'(0));
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("post reset valid%0d", k), 512'(o2_valid), 512'(0));
      end

      // 4-lane, 24-bit variant.
      for (int c = 0; c < 80; c++) begin
         rand_var();
         @(negedge clk);
      end
      v_in_valid = 1'b0;
      repeat (4) @(negedge clk);

      chk("drain", 512'({q1.size(), q2.size(), qv.size()}), 512'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
